// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: MSB-first byte serialiser with a comma preamble and idle fill.
// Optional periodic skip-byte insertion is enabled by defining PS_SKIP_EN.
module paralelo_serial_tx #(
  parameter int         SYNC_COUNT  = 4,
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter logic [7:0] SKIP_BYTE   = 8'h7C,
  parameter int         SKIP_PERIOD = 16
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out
);

  typedef enum logic {
    ST_SYNC   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t      state_q,    state_d;
  logic [7:0]  shreg_q,    shreg_d;
  logic [2:0]  bit_cnt_q,  bit_cnt_d;
  logic [3:0]  sync_cnt_q, sync_cnt_d;
  logic        active_q,   active_d;
  logic        load_slot;
  logic        skip_slot;

  // Out-of-range configurations break the counter widths or make the skip byte indistinguishable.
  if (SYNC_COUNT < 1 || SYNC_COUNT > 15) begin : g_bad_sync_count
    $error("paralelo_serial_tx: SYNC_COUNT must be in 1..15");
  end
  if (SKIP_PERIOD < 2 || SKIP_PERIOD > 255) begin : g_bad_skip_period
    $error("paralelo_serial_tx: SKIP_PERIOD must be in 2..255");
  end
  if (SKIP_BYTE == COMMA) begin : g_bad_skip_byte
    $error("paralelo_serial_tx: SKIP_BYTE must differ from COMMA");
  end

  assign load_slot = (bit_cnt_q == 3'd7);

`ifdef PS_SKIP_EN
  logic [7:0] slot_cnt_q, slot_cnt_d;

  assign skip_slot = (state_q == ST_ACTIVE) && (slot_cnt_q == 8'(SKIP_PERIOD - 1));

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      slot_cnt_q <= 8'd0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
    end
  end

  // Only ACTIVE load edges advance the slot counter; it sits at zero during SYNC.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    if (state_q != ST_ACTIVE) begin
      slot_cnt_d = 8'd0;
    end else if (load_slot) begin
      slot_cnt_d = skip_slot ? 8'd0 : slot_cnt_q + 8'd1;
    end
  end
`else
  assign skip_slot = 1'b0;
`endif

  assign ready_out  = (state_q == ST_ACTIVE) && load_slot && !skip_slot;
  assign data_out   = shreg_q[7];
  assign active_out = active_q;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SYNC;
      shreg_q    <= 8'h00;
      bit_cnt_q  <= 3'd7;
      sync_cnt_q <= 4'd0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
      active_q   <= active_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = {shreg_q[6:0], 1'b0};
    bit_cnt_d  = bit_cnt_q + 3'd1;
    sync_cnt_d = sync_cnt_q;
    active_d   = active_q;

    if (load_slot) begin
      bit_cnt_d = 3'd0;
      unique case (state_q)
        ST_SYNC: begin
          shreg_d = COMMA;
          if (sync_cnt_q != 4'(SYNC_COUNT)) begin
            sync_cnt_d = sync_cnt_q + 4'd1;
          end
          // The last preamble comma and the ACTIVE flag land on the same edge.
          if (sync_cnt_q == 4'(SYNC_COUNT - 1)) begin
            state_d  = ST_ACTIVE;
            active_d = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (skip_slot) begin
            shreg_d = SKIP_BYTE;
          end else if (valid_in) begin
            shreg_d = data_in;
          end else begin
            shreg_d = COMMA;
          end
        end
        default: begin
          state_d = ST_SYNC;
        end
      endcase
    end
  end

endmodule
